param_memory: RTL and testbench

//  Parametrised single-port synchronous RAM; successor of the fixed 64x6 scratch memory.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_clear_seq.sv | 61 ++++++
 rtl/param_memory.sv | 198 +++++++++++++++++++
 tb/tb_param_memory.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the parametrised memory family.
// Consumed by param_memory and later multi-port variants.
package mem_pkg;

  typedef enum logic [0:0] {
    MEM_CLEAR = 1'b0,
    MEM_READY = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } mem_op_e;

  localparam int READ_LAT_MAX = 2;
  localparam int PARITY_MAX_W = 256;

  // Even parity; zero-extension of narrower words leaves the result unchanged.
  function automatic logic parity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Post-reset clear sequencer: sweeps every word address once, then stays READY
// until the next reset.
module mem_clear_seq
  import mem_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // Next-state logic for the sweep FSM and pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      MEM_CLEAR: begin
        if (ptr_q == LAST_ADDR) begin
          state_d = MEM_READY;
          ptr_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = MEM_CLEAR;
          ptr_d   = ptr_q + ADDR_W'(1);
        end
      end
      MEM_READY: begin
        state_d = MEM_READY;
        ptr_d   = {ADDR_W{1'b0}};
      end
      default: begin
        state_d = MEM_CLEAR;
        ptr_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State and pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MEM_CLEAR;
      ptr_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy_o     = (state_q == MEM_CLEAR);
  assign clr_we_o   = (state_q == MEM_CLEAR);
  assign clr_addr_o = ptr_q;

endmodule

// File: rtl/param_memory.sv
// Parametrised single-port synchronous RAM with post-reset clear sweep and read-valid strobe.
// Optional per-word even parity (perr/perr_inj ports) is enabled by defining MEM_PARITY_EN.
module param_memory
  import mem_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ren,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
`ifdef MEM_PARITY_EN
  input  logic              perr_inj,
  output logic              perr,
`endif
  output logic [DATA_W-1:0] dout,
  output logic              rvalid,
  output logic              busy,
  output logic              oor
);

`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem_q [DEPTH];

  logic              busy_s;
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  mem_op_e           op_s;
  logic              in_range_s;
  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [MEM_W-1:0]  wdata_s;
  logic [MEM_W-1:0]  user_word_s;
  logic [MEM_W-1:0]  rd_word_s;

  logic [DATA_W-1:0] s1_data_d, s1_data_q;
  logic              s1_valid_d, s1_valid_q;
  logic              s1_oor_d, s1_oor_q;
`ifdef MEM_PARITY_EN
  logic              s1_perr_d, s1_perr_q;
`endif

  mem_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .busy_o     (busy_s),
    .clr_we_o   (clr_we_s),
    .clr_addr_o (clr_addr_s)
  );

  assign in_range_s = (32'(addr) < 32'(DEPTH));
  assign rd_word_s  = mem_q[addr];

`ifdef MEM_PARITY_EN
  assign user_word_s = {parity(PARITY_MAX_W'(din)) ^ perr_inj, din};
`else
  assign user_word_s = din;
`endif

  // Request decode: read wins over write, and nothing is accepted during the sweep.
  always_comb begin
    op_s = OP_IDLE;
    if (busy_s) begin
      op_s = OP_IDLE;
    end else if (ren) begin
      op_s = OP_READ;
    end else if (wen) begin
      op_s = OP_WRITE;
    end else begin
      op_s = OP_IDLE;
    end
  end

  // Array write port: the sweep owns it while busy, the user port afterwards.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = clr_addr_s;
    wdata_s = {MEM_W{1'b0}};
    if (busy_s) begin
      we_s    = clr_we_s;
      waddr_s = clr_addr_s;
      wdata_s = {MEM_W{1'b0}};
    end else begin
      we_s    = (op_s == OP_WRITE) && in_range_s;
      waddr_s = addr;
      wdata_s = user_word_s;
    end
  end

  // Storage array; contents are deliberately not reset, the sweep zeroes them.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[waddr_s] <= wdata_s;
    end
  end

  // First read stage: out-of-range reads still return a valid (zero) word.
  always_comb begin
    s1_data_d  = {DATA_W{1'b0}};
    s1_valid_d = 1'b0;
    s1_oor_d   = 1'b0;
`ifdef MEM_PARITY_EN
    s1_perr_d  = 1'b0;
`endif
    if (op_s == OP_READ) begin
      s1_valid_d = 1'b1;
      if (in_range_s) begin
        s1_data_d = rd_word_s[DATA_W-1:0];
`ifdef MEM_PARITY_EN
        s1_perr_d = parity(PARITY_MAX_W'(rd_word_s[DATA_W-1:0])) ^ rd_word_s[DATA_W];
`endif
      end else begin
        s1_oor_d = 1'b1;
      end
    end else begin
      s1_valid_d = 1'b0;
    end
  end

  // First read stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q  <= {DATA_W{1'b0}};
      s1_valid_q <= 1'b0;
      s1_oor_q   <= 1'b0;
`ifdef MEM_PARITY_EN
      s1_perr_q  <= 1'b0;
`endif
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
      s1_oor_q   <= s1_oor_d;
`ifdef MEM_PARITY_EN
      s1_perr_q  <= s1_perr_d;
`endif
    end
  end

  generate
    if (READ_LAT >= READ_LAT_MAX) begin : g_lat2
      logic [DATA_W-1:0] s2_data_q;
      logic              s2_valid_q;
      logic              s2_oor_q;
`ifdef MEM_PARITY_EN
      logic              s2_perr_q;
`endif

      // Extra output register stage; the whole zero/valid pattern shifts by one cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_data_q  <= {DATA_W{1'b0}};
          s2_valid_q <= 1'b0;
          s2_oor_q   <= 1'b0;
`ifdef MEM_PARITY_EN
          s2_perr_q  <= 1'b0;
`endif
        end else begin
          s2_data_q  <= s1_data_q;
          s2_valid_q <= s1_valid_q;
          s2_oor_q   <= s1_oor_q;
`ifdef MEM_PARITY_EN
          s2_perr_q  <= s1_perr_q;
`endif
        end
      end

      assign dout   = s2_data_q;
      assign rvalid = s2_valid_q;
      assign oor    = s2_oor_q;
`ifdef MEM_PARITY_EN
      assign perr   = s2_perr_q;
`endif
    end else begin : g_lat1
      assign dout   = s1_data_q;
      assign rvalid = s1_valid_q;
      assign oor    = s1_oor_q;
`ifdef MEM_PARITY_EN
      assign perr   = s1_perr_q;
`endif
    end
  endgenerate

  assign busy = busy_s;

endmodule

// File: tb/tb_param_memory.sv
// Bench for param_memory: three instances (64x8 lat1, 64x8 lat2, 48x8 lat1) share one
// stimulus stream and are checked every cycle against a word-level model.
module tb_param_memory;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       oor;
    logic       perr;
  } rec_t;

  logic       clk;
  logic       rst_n;
  logic       ren;
  logic       wen;
  logic [5:0] addr;
  logic [7:0] din;
  logic       inj;

  logic [7:0] dout_w   [3];
  logic       rvalid_w [3];
  logic       busy_w   [3];
  logic       oor_w    [3];
  logic       perr_w   [3];

  int   total;
  int   bad;
  int   dep_a    [3];
  int   lat_a    [3];
  int   e_cnt    [3];
  int   busy_cnt [3];
  logic [7:0] mmem [3][64];
  logic       mpar [3][64];
  rec_t last_rec [3];
  rec_t ex_now   [3];

  param_memory #(.DATA_W(8), .DEPTH(64), .ADDR_W(6), .READ_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ren(ren), .wen(wen), .addr(addr), .din(din),
`ifdef MEM_PARITY_EN
    .perr_inj(inj), .perr(perr_w[0]),
`endif
    .dout(dout_w[0]), .rvalid(rvalid_w[0]), .busy(busy_w[0]), .oor(oor_w[0])
  );

  param_memory #(.DATA_W(8), .DEPTH(64), .ADDR_W(6), .READ_LAT(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ren(ren), .wen(wen), .addr(addr), .din(din),
`ifdef MEM_PARITY_EN
    .perr_inj(inj), .perr(perr_w[1]),
`endif
    .dout(dout_w[1]), .rvalid(rvalid_w[1]), .busy(busy_w[1]), .oor(oor_w[1])
  );

  param_memory #(.DATA_W(8), .DEPTH(48), .ADDR_W(6), .READ_LAT(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ren(ren), .wen(wen), .addr(addr), .din(din),
`ifdef MEM_PARITY_EN
    .perr_inj(inj), .perr(perr_w[2]),
`endif
    .dout(dout_w[2]), .rvalid(rvalid_w[2]), .busy(busy_w[2]), .oor(oor_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  // One clock cycle: advance the model with the request, then compare all outputs.
  task automatic step(input logic r, input logic w, input logic [5:0] a, input logic [7:0] d);
    rec_t cur;
    ren = r; wen = w; addr = a; din = d;
    for (int k = 0; k < 3; k++) begin
      cur.data = 8'h00; cur.valid = 1'b0; cur.oor = 1'b0; cur.perr = 1'b0;
      if (e_cnt[k] >= dep_a[k]) begin
        if (r) begin
          cur.valid = 1'b1;
          if (int'(a) < dep_a[k]) begin
            cur.data = mmem[k][a];
            cur.perr = ((^mmem[k][a]) != mpar[k][a]);
          end else begin
            cur.oor = 1'b1;
          end
        end else if (w && (int'(a) < dep_a[k])) begin
          mmem[k][a] = d;
          mpar[k][a] = (^d) ^ inj;
        end
      end
      e_cnt[k]++;
      ex_now[k]   = (lat_a[k] == 1) ? cur : last_rec[k];
      last_rec[k] = cur;
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (busy_w[k] === 1'b1) busy_cnt[k]++;
      chk("busy",   k, 32'(busy_w[k]),   32'(e_cnt[k] < dep_a[k]));
      chk("dout",   k, 32'(dout_w[k]),   32'(ex_now[k].data));
      chk("rvalid", k, 32'(rvalid_w[k]), 32'(ex_now[k].valid));
      chk("oor",    k, 32'(oor_w[k]),    32'(ex_now[k].oor));
`ifdef MEM_PARITY_EN
      chk("perr",   k, 32'(perr_w[k]),   32'(ex_now[k].perr));
`endif
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ren = 1'b0; wen = 1'b0; inj = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e_cnt[k] = 0;
      busy_cnt[k] = 0;
      last_rec[k].data = 8'h00; last_rec[k].valid = 1'b0;
      last_rec[k].oor = 1'b0;   last_rec[k].perr = 1'b0;
      for (int j = 0; j < 64; j++) begin
        mmem[k][j] = 8'h00;
        mpar[k][j] = 1'b0;
      end
    end
    #3;
    for (int k = 0; k < 3; k++) begin
      chk("rst_dout",   k, 32'(dout_w[k]),   32'h0);
      chk("rst_rvalid", k, 32'(rvalid_w[k]), 32'h0);
      chk("rst_oor",    k, 32'(oor_w[k]),    32'h0);
      chk("rst_busy",   k, 32'(busy_w[k]),   32'h1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (busy_w[k] === 1'b1) busy_cnt[k]++;
    end
  endtask

  initial begin
    total = 0; bad = 0;
    dep_a[0] = 64; dep_a[1] = 64; dep_a[2] = 48;
    lat_a[0] = 1;  lat_a[1] = 2;  lat_a[2] = 1;
    rst_n = 1'b1; ren = 1'b0; wen = 1'b0; addr = 6'd0; din = 8'h00; inj = 1'b0;
    #1;

    // Sweep length and cleared contents
    do_reset();
    for (int i = 0; i < 70; i++) step(1'b0, 1'b0, 6'd0, 8'h00);
    chk("sweep_len", 0, 32'(busy_cnt[0]), 32'd64);
    chk("sweep_len", 1, 32'(busy_cnt[1]), 32'd64);
    chk("sweep_len", 2, 32'(busy_cnt[2]), 32'd48);
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 6'(i), 8'h00);
    step(1'b0, 1'b0, 6'd0, 8'h00);

    // Write then read, then idle
    step(1'b0, 1'b1, 6'd5, 8'hA5);
    step(1'b1, 1'b0, 6'd5, 8'h00);
    chk("lit_rd5", 0, 32'(dout_w[0]), 32'hA5);
    chk("lit_rv5", 0, 32'(rvalid_w[0]), 32'h1);
    step(1'b0, 1'b0, 6'd0, 8'h00);
    chk("lit_idle", 0, {24'h0, dout_w[0]}, 32'h0);
    chk("lit_idle_rv", 0, 32'(rvalid_w[0]), 32'h0);
    chk("lit_rd5_lat2", 1, 32'(dout_w[1]), 32'hA5);

    // Simultaneous ren/wen is a read only
    step(1'b0, 1'b1, 6'd3, 8'h11);
    step(1'b1, 1'b1, 6'd3, 8'h3C);
    chk("lit_rw", 0, 32'(dout_w[0]), 32'h11);
    step(1'b1, 1'b0, 6'd3, 8'h00);
    chk("lit_rw_keep", 0, 32'(dout_w[0]), 32'h11);

    // Back-to-back reads on the two-stage pipeline
    step(1'b0, 1'b1, 6'd0, 8'h01);
    step(1'b0, 1'b1, 6'd1, 8'h02);
    step(1'b0, 1'b1, 6'd2, 8'h03);
    step(1'b1, 1'b0, 6'd0, 8'h00);
    step(1'b1, 1'b0, 6'd1, 8'h00);
    chk("lit_b2b0", 1, 32'(dout_w[1]), 32'h01);
    step(1'b1, 1'b0, 6'd2, 8'h00);
    chk("lit_b2b1", 1, 32'(dout_w[1]), 32'h02);
    step(1'b0, 1'b0, 6'd0, 8'h00);
    chk("lit_b2b2", 1, 32'(dout_w[1]), 32'h03);
    step(1'b0, 1'b0, 6'd0, 8'h00);
    chk("lit_b2b_end", 1, 32'(rvalid_w[1]), 32'h0);

    // Out-of-range address on the 48-word instance
    step(1'b0, 1'b1, 6'd50, 8'h77);
    step(1'b1, 1'b0, 6'd50, 8'h00);
    chk("lit_oor_d", 2, 32'(dout_w[2]), 32'h0);
    chk("lit_oor_v", 2, 32'(rvalid_w[2]), 32'h1);
    chk("lit_oor_o", 2, 32'(oor_w[2]), 32'h1);
    chk("lit_in_range", 0, 32'(dout_w[0]), 32'h77);
    step(1'b0, 1'b0, 6'd0, 8'h00);

    // Mixed write/read-after-write patterns
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 6'((i * 13 + 7) % 64), 8'((i * 37 + 9) % 256));
      step(1'b1, 1'b0, 6'((i * 13 + 7) % 64), 8'h00);
    end
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 6'((i * 13 + 7) % 64), 8'h00);

`ifdef MEM_PARITY_EN
    inj = 1'b1;
    step(1'b0, 1'b1, 6'd12, 8'h5A);
    inj = 1'b0;
    step(1'b1, 1'b0, 6'd12, 8'h00);
    chk("lit_perr", 0, 32'(perr_w[0]), 32'h1);
    step(1'b0, 1'b0, 6'd0, 8'h00);
`endif

    // Reset in the middle of a sweep restarts it
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 6'd0, 8'h00);
    do_reset();
    for (int i = 0; i < 70; i++) step(1'b0, 1'b0, 6'd0, 8'h00);
    chk("resweep_len", 0, 32'(busy_cnt[0]), 32'd64);
    chk("resweep_len", 2, 32'(busy_cnt[2]), 32'd48);
    step(1'b1, 1'b0, 6'd5, 8'h00);
    step(1'b1, 1'b0, 6'd3, 8'h00);
    step(1'b0, 1'b0, 6'd0, 8'h00);
    step(1'b0, 1'b0, 6'd0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
